// File: rtl/ram_w.sv
// Simple dual-port RAM: synchronous write and synchronous read on the same clock.
// The read data register updates every cycle from rd_addr; there is no read enable.
module ram_w #(
   parameter int  DATA_WIDTH = 8,
   parameter int  WORDS      = 16,
   localparam int AW         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [WORDS];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_fifo_double.sv
// Width-doubling AXIS FIFO: pairs input beats into one word, FWFT output two cycles after the RAM write.
// write_tready drops while full (even phase included); output fields hold while read_tvalid & ~read_tready.
module axis_fifo_double #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_TUSER_WIDTH = 256,
   parameter int ADDR_WIDTH       = 12
) (
   input  logic                            aclk,
   input  logic                            reset,
   input  logic [AXIS_DATA_WIDTH-1:0]      write_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]    write_tkeep,
   input  logic [AXIS_TUSER_WIDTH-1:0]     write_tuser,
   input  logic                            write_tvalid,
   input  logic                            write_tlast,
   output logic                            write_tready,
   output logic [2*AXIS_DATA_WIDTH-1:0]    read_tdata,
   output logic [2*AXIS_DATA_WIDTH/8-1:0]  read_tkeep,
   output logic [2*AXIS_TUSER_WIDTH-1:0]   read_tuser,
   output logic                            read_tvalid,
   output logic                            read_tlast,
   input  logic                            read_tready
);

   localparam int DW     = AXIS_DATA_WIDTH;
   localparam int UW     = AXIS_TUSER_WIDTH;
   localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
   localparam int RAM_W  = 2 * (DW + KEEP_W + UW) + 1;
   localparam int PW     = ADDR_WIDTH + 1;

   logic [PW-1:0]     write_ptr_q, write_ptr_d;
   logic [PW-1:0]     write_ptr_dly_q;
   logic [PW-1:0]     read_ptr_q, read_ptr_d;
   logic [PW-1:0]     next_read_ptr;
   logic              odd_q, odd_d;
   logic [DW-1:0]     hold_data_q, hold_data_d;
   logic [KEEP_W-1:0] hold_keep_q, hold_keep_d;
   logic [UW-1:0]     hold_user_q, hold_user_d;
   logic              full, empty, wr_accept, ram_we;
   logic [RAM_W-1:0]  ram_wdata, ram_rdata;

   always_comb begin
      full = (write_ptr_q[ADDR_WIDTH] != read_ptr_q[ADDR_WIDTH]) &&
             (write_ptr_q[ADDR_WIDTH-1:0] == read_ptr_q[ADDR_WIDTH-1:0]);
      // Delayed write pointer covers the synchronous RAM read before a word is shown.
      empty        = (read_ptr_q == write_ptr_dly_q);
      write_tready = ~full & ~reset;
      read_tvalid  = ~empty & ~reset;
      wr_accept    = write_tvalid & write_tready;
      ram_we       = wr_accept & (odd_q | write_tlast);

      if (odd_q) begin
         ram_wdata = {write_tlast, write_tuser, hold_user_q, write_tkeep, hold_keep_q,
                      write_tdata, hold_data_q};
      end else begin
         ram_wdata = {write_tlast, {UW{1'b0}}, write_tuser, {KEEP_W{1'b0}}, write_tkeep,
                      {DW{1'b0}}, write_tdata};
      end

      write_ptr_d   = write_ptr_q + PW'(ram_we);
      next_read_ptr = read_ptr_q + PW'(read_tvalid & read_tready);
      read_ptr_d    = next_read_ptr;

      odd_d       = odd_q;
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      hold_user_d = hold_user_q;
      if (wr_accept) begin
         odd_d = ~odd_q & ~write_tlast;
         if (~odd_q & ~write_tlast) begin
            hold_data_d = write_tdata;
            hold_keep_d = write_tkeep;
            hold_user_d = write_tuser;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         write_ptr_q     <= '0;
         write_ptr_dly_q <= '0;
         read_ptr_q      <= '0;
         odd_q           <= 1'b0;
         hold_data_q     <= '0;
         hold_keep_q     <= '0;
         hold_user_q     <= '0;
      end else begin
         write_ptr_q     <= write_ptr_d;
         write_ptr_dly_q <= write_ptr_q;
         read_ptr_q      <= read_ptr_d;
         odd_q           <= odd_d;
         hold_data_q     <= hold_data_d;
         hold_keep_q     <= hold_keep_d;
         hold_user_q     <= hold_user_d;
      end
   end

   ram_w #(
      .DATA_WIDTH (RAM_W),
      .WORDS      (2 ** ADDR_WIDTH)
   ) u_ram (
      .clk     (aclk),
      .wr_en   (ram_we),
      .wr_addr (write_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (ram_wdata),
      .rd_addr (next_read_ptr[ADDR_WIDTH-1:0]),
      .rd_data (ram_rdata)
   );

   assign read_tdata = ram_rdata[2*DW-1:0];
   assign read_tkeep = ram_rdata[2*DW +: 2*KEEP_W];
   assign read_tuser = ram_rdata[2*DW+2*KEEP_W +: 2*UW];
   assign read_tlast = ram_rdata[RAM_W-1];

endmodule

// File: tb/tb_axis_fifo_double.sv
// Directed and randomized bench for axis_fifo_double with a packing scoreboard.
module tb_axis_fifo_double;

   localparam int DW = 32;
   localparam int UW = 8;
   localparam int AW = 2;
   localparam int KW = DW / 8;
   localparam int WW = 1 + 2*UW + 2*KW + 2*DW;

   logic            aclk = 1'b0;
   logic            reset;
   logic [DW-1:0]   write_tdata;
   logic [KW-1:0]   write_tkeep;
   logic [UW-1:0]   write_tuser;
   logic            write_tvalid;
   logic            write_tlast;
   logic            write_tready;
   logic [2*DW-1:0] read_tdata;
   logic [2*KW-1:0] read_tkeep;
   logic [2*UW-1:0] read_tuser;
   logic            read_tvalid;
   logic            read_tlast;
   logic            read_tready;

   int n_checks = 0;
   int n_fail   = 0;

   logic          rnd_mode = 1'b0;
   logic          rdy_cmd  = 1'b0;
   logic [WW-1:0] out_q[$];
   logic [WW-1:0] exp_q[$];
   logic          prev_stall = 1'b0;
   logic [WW-1:0] prev_word;
   logic [WW-1:0] cur_word;

   always #5 aclk = ~aclk;

   axis_fifo_double #(
      .AXIS_DATA_WIDTH  (DW),
      .AXIS_TUSER_WIDTH (UW),
      .ADDR_WIDTH       (AW)
   ) dut (
      .aclk         (aclk),
      .reset        (reset),
      .write_tdata  (write_tdata),
      .write_tkeep  (write_tkeep),
      .write_tuser  (write_tuser),
      .write_tvalid (write_tvalid),
      .write_tlast  (write_tlast),
      .write_tready (write_tready),
      .read_tdata   (read_tdata),
      .read_tkeep   (read_tkeep),
      .read_tuser   (read_tuser),
      .read_tvalid  (read_tvalid),
      .read_tlast   (read_tlast),
      .read_tready  (read_tready)
   );

   assign cur_word = {read_tlast, read_tuser, read_tkeep, read_tdata};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] mkw(input logic last,
                                         input logic [UW-1:0] u1, input logic [UW-1:0] u0,
                                         input logic [KW-1:0] k1, input logic [KW-1:0] k0,
                                         input logic [DW-1:0] d1, input logic [DW-1:0] d0);
      return {last, u1, u0, k1, k0, d1, d0};
   endfunction

   // Output monitor: collects accepted words and checks stability under backpressure.
   always @(negedge aclk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) check("hold_stable", {read_tvalid, cur_word}, {1'b1, prev_word});
         if (read_tvalid && read_tready) out_q.push_back(cur_word);
         prev_stall <= read_tvalid && !read_tready;
         prev_word  <= cur_word;
      end
   end

   initial begin
      read_tready = 1'b0;
      forever begin
         @(posedge aclk);
         #2;
         read_tready = rnd_mode ? ($urandom_range(0, 2) != 0) : rdy_cmd;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                       input logic l, output int stalls);
      write_tdata  = d;
      write_tkeep  = k;
      write_tuser  = u;
      write_tlast  = l;
      write_tvalid = 1'b1;
      stalls = 0;
      @(negedge aclk);
      while (!write_tready && stalls < 1000) begin
         stalls++;
         @(negedge aclk);
      end
      if (!write_tready) check("send_timeout", write_tready, 1'b1);
      @(posedge aclk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (out_q.size() < exp_q.size() && n < 3000) begin
         @(posedge aclk);
         n++;
      end
      repeat (4) @(posedge aclk);
      #1;
      check({tag, "_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) check(tag, out_q[i], exp_q[i]);
      check({tag, "_empty"}, read_tvalid, 1'b0);
      out_q.delete();
      exp_q.delete();
   endtask

   logic [DW-1:0] bd [9];
   logic [KW-1:0] bk [9];
   logic [UW-1:0] bu [9];
   int            st;
   int            len;

   initial begin
      reset        = 1'b1;
      write_tvalid = 1'b0;
      write_tdata  = '0;
      write_tkeep  = '0;
      write_tuser  = '0;
      write_tlast  = 1'b0;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      @(negedge aclk);
      check("rst_tvalid", read_tvalid, 1'b0);
      check("rst_tready", write_tready, 1'b0);
      @(posedge aclk);
      #1;
      reset = 1'b0;
      @(negedge aclk);
      check("post_rst_tready", write_tready, 1'b1);
      check("post_rst_tvalid", read_tvalid, 1'b0);
      @(posedge aclk);
      #1;

      // Packet A: four beats, latency of first word
      rdy_cmd = 1'b1;
      exp_q.push_back(mkw(1'b0, 8'hA1, 8'hA0, 4'hF, 4'hF, 32'hA000_0001, 32'hA000_0000));
      exp_q.push_back(mkw(1'b1, 8'hA3, 8'hA2, 4'hF, 4'hF, 32'hA000_0003, 32'hA000_0002));
      send(32'hA000_0000, 4'hF, 8'hA0, 1'b0, st);
      send(32'hA000_0001, 4'hF, 8'hA1, 1'b0, st);
      write_tvalid = 1'b0;
      @(negedge aclk);
      check("lat_n1", read_tvalid, 1'b0);
      @(negedge aclk);
      check("lat_n2", read_tvalid, 1'b1);
      @(posedge aclk);
      #1;
      send(32'hA000_0002, 4'hF, 8'hA2, 1'b0, st);
      send(32'hA000_0003, 4'hF, 8'hA3, 1'b1, st);
      write_tvalid = 1'b0;
      drain("pkt_a");

      // Packets B (odd length) and C (single beat), back to back
      exp_q.push_back(mkw(1'b0, 8'hB1, 8'hB0, 4'hF, 4'hF, 32'hB000_0001, 32'hB000_0000));
      exp_q.push_back(mkw(1'b1, 8'h00, 8'hB2, 4'h0, 4'hF, 32'h0, 32'hB000_0002));
      exp_q.push_back(mkw(1'b1, 8'h00, 8'hC0, 4'h0, 4'hF, 32'h0, 32'hC000_0000));
      send(32'hB000_0000, 4'hF, 8'hB0, 1'b0, st);
      send(32'hB000_0001, 4'hF, 8'hB1, 1'b0, st);
      send(32'hB000_0002, 4'hF, 8'hB2, 1'b1, st);
      check("b2_no_bubble", st, 0);
      send(32'hC000_0000, 4'hF, 8'hC0, 1'b1, st);
      check("c0_no_bubble", st, 0);
      write_tvalid = 1'b0;
      drain("pkt_bc");

      // Fill to full with the consumer stalled, then release one word
      rdy_cmd = 1'b0;
      for (int i = 0; i < 10; i += 2)
         exp_q.push_back(mkw(1'b0, 8'(i+1), 8'(i), 4'hF, 4'hF, 32'(32'hF000_0000 + i + 1),
                             32'(32'hF000_0000 + i)));
      for (int i = 0; i < 8; i++) send(32'(32'hF000_0000 + i), 4'hF, 8'(i), 1'b0, st);
      write_tdata  = 32'hF000_0008;
      write_tkeep  = 4'hF;
      write_tuser  = 8'd8;
      write_tlast  = 1'b0;
      write_tvalid = 1'b1;
      @(negedge aclk);
      check("full_tready", write_tready, 1'b0);
      check("full_tvalid", read_tvalid, 1'b1);
      @(posedge aclk);
      #1;
      check("full_still", write_tready, 1'b0);
      rdy_cmd = 1'b1;
      @(negedge aclk);
      check("full_read_cycle", write_tready, 1'b0);
      @(posedge aclk);
      #1;
      rdy_cmd = 1'b0;
      @(negedge aclk);
      check("full_release", write_tready, 1'b1);
      @(posedge aclk);
      #1;
      send(32'hF000_0009, 4'hF, 8'd9, 1'b0, st);
      check("f9_no_stall", st, 0);
      write_tvalid = 1'b0;
      rdy_cmd = 1'b1;
      drain("full");

      // Reset with a half-collected beat in the hold register
      send(32'hD000_0000, 4'hF, 8'hD0, 1'b0, st);
      write_tvalid = 1'b0;
      reset = 1'b1;
      @(negedge aclk);
      check("mid_rst_tvalid", read_tvalid, 1'b0);
      check("mid_rst_tready", write_tready, 1'b0);
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check("mid_rst_tvalid2", read_tvalid, 1'b0);
      @(posedge aclk);
      #1;
      reset = 1'b0;
      exp_q.push_back(mkw(1'b1, 8'hE1, 8'hE0, 4'hF, 4'hF, 32'hE000_0001, 32'hE000_0000));
      send(32'hE000_0000, 4'hF, 8'hE0, 1'b0, st);
      send(32'hE000_0001, 4'hF, 8'hE1, 1'b1, st);
      write_tvalid = 1'b0;
      drain("rst_pkt");

      // Random packets with random valid gaps and random ready
      rnd_mode = 1'b1;
      for (int p = 0; p < 200; p++) begin
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++) begin
            bd[i] = $urandom();
            bk[i] = 4'($urandom_range(1, 15));
            bu[i] = 8'($urandom());
         end
         for (int i = 0; i < len; i += 2) begin
            if (i + 1 < len)
               exp_q.push_back(mkw(i + 1 == len - 1, bu[i+1], bu[i], bk[i+1], bk[i], bd[i+1], bd[i]));
            else
               exp_q.push_back(mkw(1'b1, 8'h00, bu[i], 4'h0, bk[i], 32'h0, bd[i]));
         end
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               write_tvalid = 1'b0;
               repeat ($urandom_range(1, 2)) begin
                  @(posedge aclk);
                  #1;
               end
            end
            send(bd[i], bk[i], bu[i], i == len - 1, st);
         end
      end
      write_tvalid = 1'b0;
      rnd_mode = 1'b0;
      rdy_cmd  = 1'b1;
      drain("rand");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
